// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one RS232 transmitter between NUM_REQ byte-stream requesters.
// Round-robin grant, held for a whole packet until a byte tagged last has gone out; the
// transmitter's en_TX/TX_ready handshake is sequenced one byte at a time.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   req_valid_i       per-requester byte valid
//   req_data_i        byte of requester i at [8i+7:8i]
//   req_last_i        byte ends requester i's packet
//   req_ready_o       byte i accepted this cycle (transfer = valid & ready)
//   grant_o           one-hot packet owner, 0 when unowned
//   uart_tx_o         byte to transmitter TX
//   uart_en_tx_o      transmitter en_TX, one-cycle pulse per byte
//   uart_tx_ready_i   transmitter TX_ready
//   busy_o            FSM not idle
//   arb_error_o       sticky watchdog flag
//
// Optional feature: define UART_ARB_WATCHDOG_EN to enable a TIMEOUT_CYCLES watchdog that
// releases a stuck grant and sets arb_error_o. Without it arb_error_o is tied to 0.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [7:0]           uart_tx_o,
  output logic                 uart_en_tx_o,
  input  logic                 uart_tx_ready_i,
  output logic                 busy_o,
  output logic                 arb_error_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StHold
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [7:0]          tx_q, tx_d;
  logic                last_q, last_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;

`ifdef UART_ARB_WATCHDOG_EN
  logic [31:0]         wd_q, wd_d;
  logic                err_q, err_d;
  logic                wd_watched;
`endif

  logic                win_found;
  logic [IdxW-1:0]     win_idx;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    if (32'(idx) == NUM_REQ - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  // First valid requester searching upward from rr_ptr_q, wrapping to 0.
  always_comb begin
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IdxW'(cand);
      if (!win_found && req_valid_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    tx_d        = tx_q;
    last_d      = last_q;
    en_d        = 1'b0;
    req_ready_o = '0;

    unique case (state_q)
      StIdle: begin
        if (win_found && uart_tx_ready_i) begin
          req_ready_o[win_idx] = 1'b1;
          tx_d                 = req_data_i[{win_idx, 3'b000} +: 8];
          last_d               = req_last_i[win_idx];
          owner_d              = win_idx;
          grant_d              = '0;
          grant_d[win_idx]     = 1'b1;
          en_d                 = 1'b1;
          state_d              = StIssue;
        end
      end
      StIssue: begin
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (!uart_tx_ready_i) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (uart_tx_ready_i) begin
          if (last_q) begin
            rr_ptr_d = next_idx(owner_q);
            grant_d  = '0;
            state_d  = StIdle;
          end else begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        // Only the packet owner may continue; everyone else waits for the release.
        if (req_valid_i[owner_q] && uart_tx_ready_i) begin
          req_ready_o[owner_q] = 1'b1;
          tx_d                 = req_data_i[{owner_q, 3'b000} +: 8];
          last_d               = req_last_i[owner_q];
          en_d                 = 1'b1;
          state_d              = StIssue;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef UART_ARB_WATCHDOG_EN
    err_d      = err_q;
    wd_watched = (state_q == StWaitBusy) || (state_q == StWaitDone) || (state_q == StHold);
    if (state_d != state_q) begin
      wd_d = '0;
    end else if (wd_watched) begin
      wd_d = wd_q + 32'd1;
    end else begin
      wd_d = wd_q;
    end
    // Timeout overrides any handshake decided above in the same cycle.
    if (wd_watched && (wd_q >= TIMEOUT_CYCLES - 32'd1)) begin
      err_d       = 1'b1;
      grant_d     = '0;
      rr_ptr_d    = next_idx(owner_q);
      state_d     = StIdle;
      wd_d        = '0;
      req_ready_o = '0;
      tx_d        = tx_q;
      last_d      = last_q;
      en_d        = 1'b0;
    end
`endif

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      tx_q     <= 8'h00;
      last_q   <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_ARB_WATCHDOG_EN
      wd_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      tx_q     <= tx_d;
      last_q   <= last_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
`ifdef UART_ARB_WATCHDOG_EN
      wd_q     <= wd_d;
      err_q    <= err_d;
`endif
    end
  end

  // In IDLE the grant appears with the combinational accept so it covers the transfer cycle.
  assign grant_o      = (state_q == StIdle) ? req_ready_o : grant_q;
  assign uart_tx_o    = tx_q;
  assign uart_en_tx_o = en_q;
  assign busy_o       = busy_q;

`ifdef UART_ARB_WATCHDOG_EN
  assign arb_error_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign arb_error_o    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed packets push hand-computed expected
// {byte, grant} entries; a monitor pops one on every en_TX pulse.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data  = '0;
  logic [1:0]  req_last  = '0;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic [7:0]  uart_tx;
  logic        uart_en_tx;
  logic        uart_tx_ready = 1'b1;
  logic        busy;
  logic        arb_error;

  uart_tx_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (32'd100)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid),
    .req_data_i      (req_data),
    .req_last_i      (req_last),
    .req_ready_o     (req_ready),
    .grant_o         (grant),
    .uart_tx_o       (uart_tx),
    .uart_en_tx_o    (uart_en_tx),
    .uart_tx_ready_i (uart_tx_ready),
    .busy_o          (busy),
    .arb_error_o     (arb_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] grant;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_rdy_cyc = -10;
  int   en_cnt = 0;
  int   rdy0_cnt = 0;
  int   leak = 0;
  bit   t4_win = 1'b0;
  int   busy_len = 20;
  bit   stuck = 1'b0;
  int   tx_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: drops TX_ready on the ISSUE cycle, raises it busy_len cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        uart_tx_ready = 1'b1;
        tx_cnt        = 0;
      end else if (tx_cnt > 0) begin
        if (!stuck) tx_cnt--;
        if (tx_cnt == 0) uart_tx_ready = 1'b1;
      end else if (uart_en_tx) begin
        uart_tx_ready = 1'b0;
        tx_cnt        = busy_len;
      end
    end
  end

  // Monitor: pops an expectation on every en_TX pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (req_ready != 2'b00) last_rdy_cyc = cyc;
      if (req_ready[0]) rdy0_cnt++;
      if ($countones(req_ready) > 1) leak++;
      if (t4_win && (req_ready[1] || grant != 2'b01)) leak++;
      if (uart_en_tx) begin
        en_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL send: unexpected byte %h grant %b, nothing expected", uart_tx, grant);
        end else begin
          e = exp_q.pop_front();
          if (uart_tx !== e.data || grant !== e.grant || last_rdy_cyc != cyc - 1) begin
            errors++;
            $display("FAIL send: got byte %h grant %b latency %0d, want byte %h grant %b latency 1",
                     uart_tx, grant, cyc - last_rdy_cyc, e.data, e.grant);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Present one byte from requester r and hold it until accepted.
  task automatic send(input int r, input logic [7:0] d, input logic l);
    int t = 0;
    @(negedge clk);
    req_valid[r]          = 1'b1;
    req_data[8*r +: 8]    = d;
    req_last[r]           = l;
    forever begin
      #1;
      if (req_ready[r]) break;
      t++;
      if (t > 2000) begin
        checks++;
        errors++;
        $display("FAIL accept timeout: requester %0d byte %h never accepted", r, d);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    #2;
    chk("reset outputs", {req_ready, grant, uart_tx, uart_en_tx, busy, arb_error}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single-byte packet, slow transmitter; leaves rr_ptr at 1.
    busy_len = 20;
    rdy0_cnt = 0;
    en_cnt   = 0;
    exp_q.push_back({8'hA5, 2'b01});
    send(0, 8'hA5, 1'b1);
    drain();
    chk("t1 ready0 pulses", rdy0_cnt, 1);
    chk("t1 en pulses", en_cnt, 1);
    chk("t1 grant busy after", {grant, busy}, 0);

    // rr_ptr=1: requester 1's packet wins and runs contiguously, then requester 0.
    busy_len = 3;
    exp_q.push_back({8'h41, 2'b10});
    exp_q.push_back({8'h42, 2'b10});
    exp_q.push_back({8'h43, 2'b10});
    exp_q.push_back({8'h55, 2'b01});
    fork
      begin
        send(1, 8'h41, 1'b0);
        send(1, 8'h42, 1'b0);
        send(1, 8'h43, 1'b1);
      end
      send(0, 8'h55, 1'b1);
    join
    drain();

    // Gapped packet from requester 0 holds the grant against a waiting requester 1.
    do_reset();
    leak = 0;
    exp_q.push_back({8'h61, 2'b01});
    exp_q.push_back({8'h62, 2'b01});
    exp_q.push_back({8'h63, 2'b01});
    exp_q.push_back({8'h71, 2'b10});
    fork
      begin
        send(0, 8'h61, 1'b0);
        t4_win = 1'b1;
        repeat (7) @(negedge clk);
        send(0, 8'h62, 1'b0);
        repeat (7) @(negedge clk);
        send(0, 8'h63, 1'b1);
        t4_win = 1'b0;
      end
      send(1, 8'h71, 1'b1);
    join
    drain();
    chk("t4 hold leaks", leak, 0);

    // Both requesters always valid with single-byte packets: strict alternation.
    do_reset();
    exp_q.push_back({8'h11, 2'b01});
    exp_q.push_back({8'h22, 2'b10});
    exp_q.push_back({8'h11, 2'b01});
    exp_q.push_back({8'h22, 2'b10});
    fork
      begin
        send(0, 8'h11, 1'b1);
        send(0, 8'h11, 1'b1);
      end
      begin
        send(1, 8'h22, 1'b1);
        send(1, 8'h22, 1'b1);
      end
    join
    drain();

    // Reset in WAIT_DONE mid-packet; rr_ptr was 1 before, must restart at 0.
    exp_q.push_back({8'h30, 2'b01});
    send(0, 8'h30, 1'b1);
    drain();
    busy_len = 20;
    exp_q.push_back({8'h81, 2'b10});
    send(1, 8'h81, 1'b0);
    repeat (5) @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("t5 reset outputs", {req_ready, grant, uart_tx, uart_en_tx, busy, arb_error}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    busy_len = 3;
    exp_q.push_back({8'h90, 2'b01});
    exp_q.push_back({8'h91, 2'b10});
    fork
      send(0, 8'h90, 1'b1);
      send(1, 8'h91, 1'b1);
    join
    drain();

    // Transmitter never finishes.
    stuck = 1'b1;
    busy_len = 1;
    exp_q.push_back({8'hC3, 2'b01});
    send(0, 8'hC3, 1'b1);
    repeat (150) @(negedge clk);
    #1;
`ifdef UART_ARB_WATCHDOG_EN
    chk("t6 watchdog err grant busy", {arb_error, grant, busy}, {1'b1, 2'b00, 1'b0});
`else
    chk("t6 stuck err grant busy", {arb_error, grant, busy}, {1'b0, 2'b01, 1'b1});
`endif
    chk("queue empty", exp_q.size(), 0);
    chk("onehot leaks", leak, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single RS232 transmitter between NUM_REQ byte-stream requesters (CPU, debug monitor, ...). Each requester presents bytes on a valid/ready handshake; the arbiter grants round-robin, holds the grant for the whole packet until a byte tagged `last` is sent, and sequences the transmitter's `en_TX`/`TX_ready` handshake one byte at a time. It sits between the requesters and the RS232 TX port.

## Interface
- NUM_REQ, default 2: number of requesters, 2..8.
- TIMEOUT_CYCLES, default 32'd2000000: watchdog limit in clk cycles; used only with the watchdog macro.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  requester i has a byte.
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte ends requester i's packet.
- req_ready  out  NUM_REQ  byte i accepted this cycle; transfer = valid & ready.
- grant  out  NUM_REQ  one-hot current owner; 0 when unowned.
- uart_tx  out  8  byte to transmitter `TX`.
- uart_en_tx  out  1  to transmitter `en_TX`.
- uart_tx_ready  in  1  from transmitter `TX_ready`.
- busy  out  1  FSM not in IDLE.
- arb_error  out  1  sticky watchdog flag.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD.
- IDLE: winner = first i with req_valid[i], searching upward from rr_ptr with wrap to 0. If a winner exists and uart_tx_ready=1, req_ready[winner]=1 (combinational), byte and last latched, owner=winner → ISSUE. Otherwise stay.
- ISSUE: uart_en_tx=1 for exactly this cycle → WAIT_BUSY.
- WAIT_BUSY: wait for uart_tx_ready=0 → WAIT_DONE.
- WAIT_DONE: wait for uart_tx_ready=1. If latched last=1: rr_ptr = (owner+1) mod NUM_REQ, grant cleared → IDLE. Else → HOLD.
- HOLD: only owner is eligible; when req_valid[owner]=1 and uart_tx_ready=1, req_ready[owner]=1, byte latched → ISSUE. Other requesters are ignored.
- req_ready is never asserted to more than one requester, and never outside IDLE/HOLD.
- uart_tx holds the latched byte from ISSUE until the next transfer; it does not change while the transmitter is busy.
- In IDLE, arbitration is re-evaluated every cycle: a requester may drop valid before ready with no effect. Once granted in HOLD, the requester must keep valid, data and last stable until ready.
- grant is the one-hot owner from the transfer cycle through the packet's final WAIT_DONE exit.
- Reset values: req_ready=0, grant=0, uart_tx=8'h00, uart_en_tx=0, busy=0, arb_error=0, rr_ptr=0, state IDLE. Reset mid-packet drops the packet immediately. uart_en_tx goes low asynchronously.

## Timing
- Transfer at cycle T (IDLE or HOLD). ISSUE, with uart_en_tx=1, at T+1. WAIT_BUSY at T+2.
- The transmitter drops TX_ready at T+2, so WAIT_DONE is entered at T+3.
- The next transfer is possible on the first cycle that WAIT_DONE observes uart_tx_ready=1 plus one cycle (HOLD/IDLE).
- Simultaneous valid from all requesters with rr_ptr=k: requester k wins.
- req_last=1 on a single-byte packet releases the grant after that byte.

## Configuration
- UART_ARB_WATCHDOG_EN defined: a 32-bit counter clears on every state change and increments in WAIT_BUSY, WAIT_DONE and HOLD.
- On reaching TIMEOUT_CYCLES, arb_error is set (sticky until reset), the grant is released, rr_ptr = owner+1, and the FSM goes → IDLE.
- Not defined: no counter. The FSM waits indefinitely and arb_error is tied to 0.

## Test plan
- Requester 0 sends one byte 8'hA5 with last=1, transmitter model holding TX_ready low for 20 cycles → req_ready[0] pulses once, uart_en_tx pulses once at T+1 with uart_tx=8'hA5, grant 01→00, rr_ptr=1.
- Both requesters valid every cycle with single-byte packets (8'h11 from 0, 8'h22 from 1) → sends alternate 11,22,11,22, starting with 11 after reset.
- Requester 1 sends a 3-byte packet 41,42,43 (last on 43) while requester 0 is valid throughout → 41,42,43 are sent contiguously, then requester 0's byte; grant stays 10 across the packet.
- Requester 0 with 7 idle cycles between packet bytes and requester 1 valid → grant is held in HOLD and req_ready[1] stays 0 throughout.
- Assert rst in WAIT_DONE mid-packet → all outputs at reset values the same cycle; a fresh byte from requester 1 is then arbitrated normally starting from rr_ptr=0.
- With UART_ARB_WATCHDOG_EN and TIMEOUT_CYCLES=100: the model never raises TX_ready → arb_error=1 after 100 cycles in WAIT_DONE, grant=0, state IDLE. Without the macro, arb_error stays 0 and busy stays 1.
